// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder controller around an external 4-bit adder.
// Adds one nibble per clock, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             last;

    // Partial sum after this cycle: new nibble enters at the top, older ones move down.
    always_comb begin
        last    = (cnt == CW'(NIB - 1));
        acc_nxt = (acc >> 4) | (WIDTH'(add_sum) << (WIDTH - 4));
    end

    // Next-state logic and adder drive; the adder sees zeros outside RUN.
    always_comb begin
        state_d = state_q;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = sa[3:0];
                add_b   = sb[3:0];
                add_cin = c;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; busy/done are decoded from the next state so they come out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    // Operand capture, nibble shifting, carry chain and final result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa  <= op_a;
                        sb  <= op_b;
                        c   <= carry_in;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    c   <= add_cout;
                    sa  <= sa >> 4;
                    sb  <= sb >> 4;
                    // Hold the counter on the final nibble so it never wraps.
                    if (!last) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        result    <= acc_nxt;
                        carry_out <= add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: WIDTH=16 and WIDTH=4 instances, each wired to a
// behavioural 4-bit adder, checked cycle by cycle against a timing/arithmetic model.
module tb_nibble_serial_adder;

    localparam int unsigned NIB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        start, carry_in;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout, busy, done, carry_out;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .carry_in(carry_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out)
    );

    // 4-bit instance
    logic       start4, carry_in4;
    logic [3:0] op_a4, op_b4, result4;
    logic [3:0] add_a4, add_b4, add_sum4;
    logic       add_cin4, add_cout4, busy4, done4, carry_out4;

    assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .carry_in(carry_in4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4), .busy(busy4), .done(done4),
        .result(result4), .carry_out(carry_out4)
    );

    int ntests = 0;
    int nfail  = 0;

    // Scoreboards: {carry, sum} pushed at accept, popped at done.
    logic [16:0] sbq[$];
    logic [4:0]  q4[$];

    // Model of the 16-bit instance: 0 = idle, 1..NIB = RUN, NIB+1 = DONE.
    int          mcnt;
    logic [15:0] ma, mb;
    logic        mc;
    logic [16:0] mres;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the 16-bit instance with model update and full output check.
    task automatic step16(input logic st, input logic [15:0] a, input logic [15:0] b,
                          input logic ci);
        int          k;
        logic [31:0] mask, lo;
        start    = st;
        op_a     = a;
        op_b     = b;
        carry_in = ci;
        @(posedge clk);
        #1;
        if (mcnt == 0) begin
            if (st) begin
                mcnt = 1;
                ma   = a;
                mb   = b;
                mc   = ci;
                sbq.push_back(17'(a) + 17'(b) + 17'(ci));
            end
        end else if (mcnt == NIB + 1) begin
            mcnt = 0;
        end else begin
            mcnt++;
        end
        chk("busy", 32'(busy), 32'(mcnt != 0));
        chk("done", 32'(done), 32'(mcnt == NIB + 1));
        if (mcnt == NIB + 1) begin
            chk("scoreboard_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) mres = sbq.pop_front();
        end
        chk("result", 32'(result), 32'(mres[15:0]));
        chk("carry_out", 32'(carry_out), 32'(mres[16]));
        if (mcnt >= 1 && mcnt <= NIB) begin
            k    = mcnt - 1;
            mask = (32'd1 << (4 * k)) - 32'd1;
            lo   = (32'(ma) & mask) + (32'(mb) & mask) + 32'(mc);
            chk("add_a", 32'(add_a), (32'(ma) >> (4 * k)) & 32'hF);
            chk("add_b", 32'(add_b), (32'(mb) >> (4 * k)) & 32'hF);
            chk("add_cin", 32'(add_cin), (lo >> (4 * k)) & 32'd1);
        end else begin
            chk("add_a_idle", 32'(add_a), 32'd0);
            chk("add_b_idle", 32'(add_b), 32'd0);
            chk("add_cin_idle", 32'(add_cin), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_carry_out"}, 32'(carry_out), 32'd0);
        chk({tag, "_add_a"}, 32'(add_a), 32'd0);
        chk({tag, "_add_b"}, 32'(add_b), 32'd0);
        chk({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    endtask

    initial begin
        logic [4:0] e4;
        rst_n = 1'b0;
        start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
        start4 = 1'b0; op_a4 = '0; op_b4 = '0; carry_in4 = 1'b0;
        mcnt = 0; ma = '0; mb = '0; mc = 1'b0; mres = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset16");
        chk("reset4_busy", 32'(busy4), 32'd0);
        chk("reset4_result", 32'(result4), 32'd0);
        rst_n = 1'b1;
        step16(1'b0, 16'h0, 16'h0, 1'b0);

        // Basic add and handshake timing
        step16(1'b1, 16'h1234, 16'h4321, 1'b0);
        repeat (6) step16(1'b0, 16'h0, 16'h0, 1'b0);

        // Carry ripples through every nibble
        step16(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        repeat (6) step16(1'b0, 16'h0, 16'h0, 1'b0);

        // All-ones with carry-in; operands and start churn during RUN
        step16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        repeat (6) step16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        step16(1'b0, 16'h0, 16'h0, 1'b0);

        // start held high with changing operands
        repeat (20) step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        repeat (6) step16(1'b0, 16'h0, 16'h0, 1'b0);

        // Reset during the second RUN cycle aborts the operation
        step16(1'b1, 16'h1111, 16'h2222, 1'b0);
        step16(1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        mcnt = 0;
        mres = '0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step16(1'b0, 16'h0, 16'h0, 1'b0);
        step16(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        repeat (6) step16(1'b0, 16'h0, 16'h0, 1'b0);
        chk("post_abort_result", 32'(result), 32'h1000);
        chk("post_abort_cout", 32'(carry_out), 32'd0);

        // WIDTH=4: single RUN cycle
        start4 = 1'b1; op_a4 = 4'h9; op_b4 = 4'h8; carry_in4 = 1'b1;
        q4.push_back(5'(op_a4) + 5'(op_b4) + 5'(carry_in4));
        @(posedge clk);
        #1;
        start4 = 1'b0; op_a4 = 4'h3; op_b4 = 4'h3; carry_in4 = 1'b0;
        chk("w4_busy_run", 32'(busy4), 32'd1);
        chk("w4_done_run", 32'(done4), 32'd0);
        chk("w4_add_a", 32'(add_a4), 32'h9);
        chk("w4_add_cin", 32'(add_cin4), 32'd1);
        @(posedge clk);
        #1;
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_busy_done", 32'(busy4), 32'd1);
        chk("w4_add_a_done", 32'(add_a4), 32'd0);
        chk("w4_q_nonempty", 32'(q4.size() != 0), 32'd1);
        e4 = (q4.size() != 0) ? q4.pop_front() : 5'd0;
        chk("w4_result", 32'(result4), 32'(e4[3:0]));
        chk("w4_cout", 32'(carry_out4), 32'(e4[4]));
        @(posedge clk);
        #1;
        chk("w4_done_after", 32'(done4), 32'd0);
        chk("w4_busy_after", 32'(busy4), 32'd0);
        chk("w4_result_held", 32'(result4), 32'h2);
        chk("w4_cout_held", 32'(carry_out4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
